// File: rtl/sram_bus_arbiter.sv
// Two-master arbiter (instruction fetch + data) in front of the SRAM-to-AXI adapter.
// One transaction at a time; the winner's request is registered and held for the adapter.
module sram_bus_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ROUND_ROBIN = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_en,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_read_data,
    input  logic                  data_en,
    input  logic [3:0]            data_write_en,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_write_data,
    output logic                  data_ready,
    output logic [DATA_WIDTH-1:0] data_read_data,
    output logic                  sram_en,
    input  logic                  sram_ready,
    output logic [3:0]            sram_write_en,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_read_data,
    output logic [DATA_WIDTH-1:0] sram_write_data
);

    typedef enum logic [2:0] {IDLE, WAIT_I, WAIT_D, DONE_I, DONE_D} state_t;

    state_t                state_q, state_d;
    logic                  last_data_q, last_data_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [3:0]            req_wstrb_q, req_wstrb_d;
    logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
    logic [DATA_WIDTH-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
    logic                  pick_data;

    // Fixed priority favours data; round robin only yields to inst if data won last.
    assign pick_data = data_en && (!inst_en || (ROUND_ROBIN == 0) || !last_data_q);

    assign inst_read_data = inst_rdata_q;
    assign data_read_data = data_rdata_q;

    always_comb begin
        state_d         = state_q;
        last_data_d     = last_data_q;
        req_addr_d      = req_addr_q;
        req_wstrb_d     = req_wstrb_q;
        req_wdata_d     = req_wdata_q;
        inst_rdata_d    = inst_rdata_q;
        data_rdata_d    = data_rdata_q;
        sram_en         = 1'b0;
        sram_addr       = req_addr_q;
        sram_write_en   = req_wstrb_q;
        sram_write_data = req_wdata_q;
        inst_ready      = 1'b0;
        data_ready      = 1'b0;

        case (state_q)
            IDLE: begin
                // Issue is gated by rst so nothing reaches the adapter while it is held in reset.
                if (!rst && sram_ready && (inst_en || data_en)) begin
                    sram_en = 1'b1;
                    if (pick_data) begin
                        sram_addr       = data_addr;
                        sram_write_en   = data_write_en;
                        sram_write_data = data_write_data;
                        last_data_d     = 1'b1;
                        state_d         = WAIT_D;
                    end else begin
                        sram_addr       = inst_addr;
                        sram_write_en   = 4'b0000;
                        sram_write_data = '0;
                        last_data_d     = 1'b0;
                        state_d         = WAIT_I;
                    end
                    req_addr_d  = sram_addr;
                    req_wstrb_d = sram_write_en;
                    req_wdata_d = sram_write_data;
                end
            end
            WAIT_I: begin
                if (sram_ready) begin
                    inst_rdata_d = sram_read_data;
                    state_d      = DONE_I;
                end
            end
            WAIT_D: begin
                if (sram_ready) begin
                    data_rdata_d = sram_read_data;
                    state_d      = DONE_D;
                end
            end
            DONE_I: begin
                inst_ready = 1'b1;
                state_d    = IDLE;
            end
            DONE_D: begin
                data_ready = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_data_q  <= 1'b0;
            req_addr_q   <= '0;
            req_wstrb_q  <= 4'b0000;
            req_wdata_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_data_q  <= last_data_d;
            req_addr_q   <= req_addr_d;
            req_wstrb_q  <= req_wstrb_d;
            req_wdata_q  <= req_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: one environment per arbitration mode, each with an adapter
// model backed by memory, two masters, and a queue scoreboard checked by a monitor.
module tb_sram_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit done [2];

  typedef struct {
    logic [31:0] data;
    bit          wr;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Power-up contents of the memory behind the adapter.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'hBFC00000) return 32'h3C08BFC0;
    return {w[15:0], ~w[15:0]} ^ 32'h13579BDF;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] st,
                                        input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic int unsigned key(input logic [31:0] a);
    return int'(a >> 2);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : env
    logic        rst, inst_en, inst_ready, data_en, data_ready, sram_en, sram_ready;
    logic [31:0] inst_addr, inst_read_data, data_addr, data_write_data, data_read_data;
    logic [31:0] sram_addr, sram_read_data, sram_write_data;
    logic [3:0]  data_write_en, sram_write_en;

    sram_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(g)) dut (
      .clk(clk), .rst(rst),
      .inst_en(inst_en), .inst_addr(inst_addr), .inst_ready(inst_ready),
      .inst_read_data(inst_read_data),
      .data_en(data_en), .data_write_en(data_write_en), .data_addr(data_addr),
      .data_write_data(data_write_data), .data_ready(data_ready),
      .data_read_data(data_read_data),
      .sram_en(sram_en), .sram_ready(sram_ready), .sram_write_en(sram_write_en),
      .sram_addr(sram_addr), .sram_read_data(sram_read_data),
      .sram_write_data(sram_write_data)
    );

    // ---------------- adapter model: busy 2 (read) / 3 (write) cycles + extra ----------------
    int          busy = 0;
    bit          rand_slow = 0;
    int          slow_extra = 0;
    logic [31:0] cap_addr = '0, cap_wd = '0, rdata = '0;
    logic [3:0]  cap_st = '0;
    logic [31:0] smem [64];
    logic [29:0] stag [64];
    bit          sval [64];

    assign sram_ready     = (busy == 0);
    assign sram_read_data = rdata;

    function automatic logic [31:0] srd(input logic [31:0] a);
      int i;
      i = int'(a[7:2]);
      return (sval[i] && stag[i] == a[31:2]) ? smem[i] : init_word(a);
    endfunction

    always @(posedge clk) begin
      if (rst) busy <= 0;
      else if (busy == 0) begin
        if (sram_en) begin
          cap_addr <= sram_addr;
          cap_st   <= sram_write_en;
          cap_wd   <= sram_write_data;
          busy     <= ((sram_write_en != 4'd0) ? 3 : 2) +
                      (rand_slow ? int'($urandom_range(0, 3)) : slow_extra);
        end
      end else begin
        busy <= busy - 1;
        if (busy == 1) begin
          if (cap_st != 4'd0) begin
            // strobes and data are taken live, as the real adapter does
            smem[int'(cap_addr[7:2])] <= merge(srd(cap_addr), sram_write_en, sram_write_data);
            stag[int'(cap_addr[7:2])] <= cap_addr[31:2];
            sval[int'(cap_addr[7:2])] <= 1'b1;
          end else rdata <= srd(cap_addr);
        end
      end
    end

    // ---------------- reference model and scoreboard ----------------
    logic [31:0] ref_mem [int unsigned];
    exp_t        iq[$];
    exp_t        dq[$];
    bit          wq[$];
    bit          last_d = 0;
    logic [31:0] ih = '0, dh = '0;
    bit          dh_known = 1;
    int          dready_cnt = 0;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(key(a)) ? ref_mem[key(a)] : init_word(a);
    endfunction

    initial begin : mon
      bit   wsel;
      exp_t e;
      forever begin
        @(negedge clk);
        if (rst) begin
          iq.delete(); dq.delete(); wq.delete();
          last_d = 0; ih = '0; dh = '0; dh_known = 1;
        end else begin
          if (sram_en) begin
            chk($sformatf("rr%0d issue_has_req", g), 32'(inst_en | data_en), 1);
            if (inst_en && data_en) wsel = (g == 0) ? 1'b1 : !last_d;
            else wsel = data_en;
            wq.push_back(wsel);
            last_d = wsel;
            chk($sformatf("rr%0d issue_addr", g), sram_addr, wsel ? data_addr : inst_addr);
            chk($sformatf("rr%0d issue_wstrb", g), 32'(sram_write_en),
                wsel ? 32'(data_write_en) : 32'd0);
            chk($sformatf("rr%0d issue_wdata", g), sram_write_data,
                wsel ? data_write_data : 32'd0);
          end
          if (inst_ready || data_ready)
            chk($sformatf("rr%0d ready_excl", g), 32'(inst_ready & data_ready), 0);
          if (inst_ready) begin
            chk($sformatf("rr%0d inst_pending", g), 32'(iq.size() > 0), 1);
            chk($sformatf("rr%0d inst_has_grant", g), 32'(wq.size() > 0), 1);
            if (wq.size() > 0) chk($sformatf("rr%0d inst_grant_owner", g), 32'(wq.pop_front()), 0);
            if (iq.size() > 0) begin
              e = iq.pop_front();
              chk($sformatf("rr%0d inst_rdata", g), inst_read_data, e.data);
              ih = e.data;
            end
          end else chk($sformatf("rr%0d inst_hold", g), inst_read_data, ih);
          if (data_ready) begin
            dready_cnt++;
            chk($sformatf("rr%0d data_pending", g), 32'(dq.size() > 0), 1);
            chk($sformatf("rr%0d data_has_grant", g), 32'(wq.size() > 0), 1);
            if (wq.size() > 0) chk($sformatf("rr%0d data_grant_owner", g), 32'(wq.pop_front()), 1);
            if (dq.size() > 0) begin
              e = dq.pop_front();
              if (!e.wr) begin
                chk($sformatf("rr%0d data_rdata", g), data_read_data, e.data);
                dh = e.data; dh_known = 1;
              end else dh_known = 0;
            end
          end else if (dh_known) chk($sformatf("rr%0d data_hold", g), data_read_data, dh);
          if (busy != 0) begin
            chk($sformatf("rr%0d no_en_in_wait", g), 32'(sram_en), 0);
            chk($sformatf("rr%0d wait_addr", g), sram_addr, cap_addr);
            chk($sformatf("rr%0d wait_wstrb", g), 32'(sram_write_en), 32'(cap_st));
            chk($sformatf("rr%0d wait_wdata", g), sram_write_data, cap_wd);
          end
        end
      end
    end

    // ---------------- masters ----------------
    task automatic inst_op(input logic [31:0] a, input logic [31:0] exp, output int lat);
      iq.push_back('{data: exp, wr: 1'b0});
      inst_addr = a; inst_en = 1'b1; lat = 0;
      forever begin
        @(negedge clk);
        if (inst_ready) break;
        lat++;
        if (lat > 300) begin
          chk($sformatf("rr%0d inst_timeout", g), 32'(inst_ready), 1);
          break;
        end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      inst_en = 1'b0;
    endtask

    task automatic data_op(input logic [31:0] a, input logic [3:0] st, input logic [31:0] wd,
                           input bit garble, output int lat);
      exp_t e;
      if (st == 4'd0) begin
        e.data = ref_rd(a); e.wr = 1'b0;
      end else begin
        ref_mem[key(a)] = merge(ref_rd(a), st, wd);
        e.data = '0; e.wr = 1'b1;
      end
      dq.push_back(e);
      data_addr = a; data_write_en = st; data_write_data = wd; data_en = 1'b1; lat = 0;
      forever begin
        @(negedge clk);
        if (data_ready) break;
        lat++;
        if (lat > 300) begin
          chk($sformatf("rr%0d data_timeout", g), 32'(data_ready), 1);
          break;
        end
        @(posedge clk); #1;
        if (garble) begin
          data_addr = $urandom; data_write_en = 4'($urandom); data_write_data = $urandom;
        end
      end
      @(posedge clk); #1;
      data_en = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [3:0] st_tab [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010,
                                4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    initial begin : stim
      int lat, la, lb, n0, gap;
      logic [31:0] a;
      rst = 1'b1; data_en = 1'b0; data_addr = '0; data_write_en = '0; data_write_data = '0;
      inst_en = 1'b1; inst_addr = 32'h0000_1010;
      repeat (3) begin
        @(negedge clk);
        chk($sformatf("rr%0d rst_sram_en", g), 32'(sram_en), 0);
        chk($sformatf("rr%0d rst_sram_wstrb", g), 32'(sram_write_en), 0);
        chk($sformatf("rr%0d rst_sram_addr", g), sram_addr, 0);
        chk($sformatf("rr%0d rst_sram_wdata", g), sram_write_data, 0);
        chk($sformatf("rr%0d rst_inst_ready", g), 32'(inst_ready), 0);
        chk($sformatf("rr%0d rst_data_ready", g), 32'(data_ready), 0);
        chk($sformatf("rr%0d rst_inst_rdata", g), inst_read_data, 0);
        chk($sformatf("rr%0d rst_data_rdata", g), data_read_data, 0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      inst_op(32'h0000_1010, init_word(32'h0000_1010), lat);
      chk($sformatf("rr%0d rst_release_lat", g), lat, 4);

      inst_op(32'hBFC0_0000, 32'h3C08_BFC0, lat);
      chk($sformatf("rr%0d inst_read_lat", g), lat, 4);
      repeat (3) begin @(posedge clk); #1; end

      data_op(32'h8000_1002, 4'b0100, 32'h00AB_0000, 1'b1, lat);
      chk($sformatf("rr%0d byte_store_lat", g), lat, 5);
      data_op(32'h8000_1000, 4'b0000, 32'h0, 1'b0, lat);
      chk($sformatf("rr%0d readback_lat", g), lat, 4);

      // contention: both masters request back to back
      fork
        for (int i = 0; i < 3; i++)
          data_op(32'h0000_8040 + 32'(i * 4), (i == 1) ? 4'b1111 : 4'b0000, $urandom, 1'b0, la);
        for (int i = 0; i < 2; i++)
          inst_op(32'h0000_1100 + 32'(i * 4), init_word(32'h0000_1100 + 32'(i * 4)), lb);
      join

      // slow adapter, then reset while the data read is still outstanding
      slow_extra = 6;
      data_en = 1'b1; data_addr = 32'h0000_8060; data_write_en = 4'b0000;
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b1; data_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; slow_extra = 0; n0 = dready_cnt;
      repeat (12) begin @(posedge clk); #1; end
      chk($sformatf("rr%0d no_ready_after_rst", g), dready_cnt - n0, 0);
      chk($sformatf("rr%0d data_rdata_cleared", g), data_read_data, 0);

      // randomized traffic from both masters against a randomly slow adapter
      rand_slow = 1;
      fork
        for (int i = 0; i < 20; i++) begin
          gap = $urandom_range(0, 3);
          repeat (gap) begin @(posedge clk); #1; end
          a = 32'h0000_1000 + (32'($urandom_range(0, 63)) << 2);
          inst_op(a, init_word(a), lb);
        end
        for (int i = 0; i < 30; i++) begin
          gap = $urandom_range(0, 3);
          repeat (gap) begin @(posedge clk); #1; end
          a = 32'h0000_8040 + (32'($urandom_range(0, 15)) << 2);
          data_op(a, st_tab[$urandom_range(0, 9)], $urandom, 1'b0, la);
        end
      join
      rand_slow = 0;
      repeat (5) begin @(posedge clk); #1; end
      chk($sformatf("rr%0d iq_drained", g), iq.size(), 0);
      chk($sformatf("rr%0d dq_drained", g), dq.size(), 0);
      chk($sformatf("rr%0d wq_drained", g), wq.size(), 0);
      done[g] = 1'b1;
    end
  end

  initial begin
    wait (done[0] && done[1]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    n_bad++;
    $display("FAIL watchdog: bench did not complete, got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
Two-master arbiter sitting directly upstream of the SRAM-to-AXI adapter. It merges the CPU instruction-fetch port (read-only) and data port (read/write) onto the adapter's single SRAM channel, one transaction at a time. It registers the winning request's address, strobe and write data so they stay stable for the whole AXI transaction, then returns a one-cycle ready pulse and registered read data to the owning master.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
ROUND_ROBIN, 0, 0 = data port has fixed priority; 1 = on simultaneous requests, grant the master not served last

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
inst_en  input  1  instruction read request; held high with stable inst_addr until inst_ready
inst_addr  input  ADDR_WIDTH  instruction address
inst_ready  output  1  one-cycle completion pulse for the instruction request
inst_read_data  output  DATA_WIDTH  fetched word; valid while inst_ready=1, held until the next inst completion
data_en  input  1  data request; held high with stable fields until data_ready
data_write_en  input  4  byte strobes; 0 = read. Legal values: 0001/0010/0100/1000/0011/1100/1111
data_addr  input  ADDR_WIDTH  data address
data_write_data  input  DATA_WIDTH  store data
data_ready  output  1  one-cycle completion pulse for the data request
data_read_data  output  DATA_WIDTH  load word; valid while data_ready=1, held until the next data completion
sram_en  output  1  request to adapter
sram_ready  input  1  adapter idle / accepting (high only in adapter idle state)
sram_write_en  output  4  strobes to adapter
sram_addr  output  ADDR_WIDTH  address to adapter
sram_read_data  input  DATA_WIDTH  adapter read data, valid in first ready-high cycle after a read
sram_write_data  output  DATA_WIDTH  store data to adapter

Behaviour:
- States: IDLE, WAIT_I, WAIT_D, DONE_I, DONE_D. Reset -> IDLE; last_grant <= INST.
- Reset values: sram_en=0, sram_write_en=0, sram_addr=0, sram_write_data=0, inst_ready=0, data_ready=0, inst_read_data=0, data_read_data=0. All output registers clear to 0.
- Reset asserted mid-transaction: returns to IDLE next edge and drops the transaction with no ready pulse. The adapter is reset in the same cycle.
- Grant rule in IDLE, only when sram_ready=1:
  - ROUND_ROBIN=0: data_en wins over inst_en.
  - ROUND_ROBIN=1: if both request, grant the one != last_grant; a single requester always wins.
- Issue cycle (IDLE, grant taken):
  - sram_en=1; sram_addr, sram_write_en and sram_write_data are driven combinationally from the winner.
  - Inst requests drive write_en=0 and write_data=0.
  - The same values are latched into req_addr/req_wstrb/req_wdata; last_grant and state update (WAIT_I or WAIT_D).
- IDLE with no request, or sram_ready=0: sram_en=0, stay in IDLE, outputs driven from held registers.
- WAIT_x: sram_en=0; sram_addr/sram_write_en/sram_write_data driven from the latched registers, which must stay stable because the adapter samples strobes and write data live. Stay while sram_ready=0.
- WAIT_x with sram_ready=1 means completion:
  - Capture sram_read_data into x_read_data (writes capture too; the value is don't-care to the master).
  - Go to DONE_x.
- DONE_x: x_ready=1 for exactly one cycle, sram_en=0, requests ignored, next state IDLE. The master may drop or change its request from the following cycle.
- inst_ready and data_ready are never both 1 in the same cycle; at most one transaction is outstanding.
- A master dropping en after issue does not abort: the transaction completes and the ready pulse is still produced.
- Latency with arready/rvalid/awready/wready all tied high:
  - read: issue at cycle 0, ready at cycle 4;
  - write: issue at cycle 0, ready at cycle 5.
  - Next issue no earlier than the cycle after DONE.
- Illegal data_write_en values are passed through unchanged; the adapter defines the result.

Test Plan:
- Reset: hold rst 3 cycles with inst_en=1 -> all outputs 0 and no sram_en while rst=1; first issue occurs on the cycle rst falls with sram_ready=1.
- Inst read: inst_addr=0xBFC00000, slave returns 0x3C08BFC0 -> sram_en one cycle at cycle 0 with write_en=0; inst_ready=1 at cycle 4 with inst_read_data=0x3C08BFC0; value held afterwards.
- Data byte store: data_write_en=0100, addr=0x80001002, wdata=0x00AB0000, inputs changed to garbage after cycle 1 -> adapter sees stable strobe 0100 / wdata 0x00AB0000 throughout; data_ready at cycle 5; inst_ready stays 0.
- Contention, ROUND_ROBIN=0: inst_en and data_en high together continuously -> data is always granted first; inst is served only after data_en drops.
- Contention, ROUND_ROBIN=1: both requesting repeatedly -> grants alternate D, I, D, I (first is D since last_grant resets to INST).
- Slow slave plus reset: arready delayed 6 cycles -> sram_en not re-asserted during WAIT; rst pulsed in WAIT_D -> IDLE next cycle, no data_ready, data_read_data=0.
